mdu_multicycle: RTL and testbench
=================================

Name: mdu_multicycle

Overview:
Parametrised multi-cycle multiply/divide unit for the E stage of the pipelined CPU. Owns HI/LO and executes MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO with configurable latency. Exposes busy for control-unit stalling. Exposes stop/restore so a pipeline flush on exception cancels or rolls back an in-flight operation.

Parameters:
DATA_W, 32, operand and HI/LO width.
MUL_CYCLES, 5, busy cycles for multiply ops (>=1).
DIV_CYCLES, 10, busy cycles for divide ops (>=1).

Ports:
clk  in  1  clock.
rst  in  1  reset; asynchronous, active-low.
dh  in  DATA_W  operand 1 (rs).
dl  in  DATA_W  operand 2 (rt).
op  in  4  operation code (mdu_pkg), sampled every rising edge.
stop  in  1  cancel in-flight op; HI/LO left at pre-op values.
restore  in  1  roll HI/LO back to the snapshot taken at the last start.
busy  out  1  operation in flight.
invalid  out  1  combinational; op unsupported, or a start/MT op issued while busy.
hi  out  DATA_W  HI register.
lo  out  DATA_W  LO register.
out  out  DATA_W  combinational; hi for MFHI, lo for MFLO, else 0.

Behaviour:
- Reset (rst=0, async): hi=lo=0, busy=0, counter=0, snapshot=0, state IDLE.
- States:
  - IDLE: on a MULT/MULTU/DIV/DIVU edge, capture snapshot {hi,lo}, compute result into pending regs, load counter = MUL_CYCLES or DIV_CYCLES, go to BUSY.
  - BUSY: decrement counter each edge. On the edge where counter==1, commit pending to {hi,lo}, go to IDLE.
- busy=1 in every cycle after the issue edge through the commit edge. Latency from issue to visible hi/lo = N cycles.
- MTHI/MTLO in IDLE: snapshot, then write dh to hi/lo on the same edge. No busy.
- Any start/MT op while BUSY is ignored and raises invalid. Control stalls these, so invalid indicates a control bug.
- MFHI/MFLO: out reflects current hi/lo regardless of busy. Control stalls MF while busy.
- Arithmetic:
  - MULT signed and MULTU unsigned give a 2*DATA_W product: hi = upper half, lo = lower half.
  - DIV/DIVU: lo = quotient, hi = remainder; remainder takes the dividend's sign.
  - Divide by zero: lo = all ones, hi = dh.
  - Signed MIN / -1: lo = MIN, hi = 0.
- stop: if BUSY, abort to IDLE on the next edge with no commit; busy=0 the cycle after. If IDLE, no effect. If stop coincides with the commit edge, stop wins.
- restore: {hi,lo} <= snapshot on the next edge and state goes to IDLE. Used when the MT/MD instruction itself is flushed from M.
- Priority on one edge: restore > stop > commit > new issue.
- A start op issued in the same cycle as stop/restore is discarded.
- Reset asserted mid-operation clears everything immediately. There is no partial commit.

Optional Feature:
MDU_MADD_EN.
- Defined: adds MADD/MADDU/MSUB/MSUBU. These use MUL_CYCLES latency and {hi,lo} +/- product (signedness per op), computed from {hi,lo} at issue. Snapshot and restore apply as for other start ops.
- Undefined: these opcodes raise invalid and are otherwise NOP.

Decomposition:
- mdu_pkg: op code constants (NOP=0, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO, MADD, MADDU, MSUB, MSUBU), state encoding (IDLE, BUSY), helper is_start/is_mt functions.
- Sub-module mdu_div_core: combinational signed/unsigned divide including the zero and overflow rules. Instantiated once.

Test Plan:
1. MULT dh=0xFFFFFFFE (-2), dl=3 -> busy for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy=0 on cycle 6.
2. DIVU dh=100, dl=7 -> busy 10 cycles; lo=14, hi=2. DIV dh=-7, dl=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. Divide edges:
   - DIV dh=5, dl=0 -> lo=0xFFFFFFFF, hi=5.
   - DIV dh=0x80000000, dl=0xFFFFFFFF -> lo=0x80000000, hi=0.
4. MTHI 0x1234; MULTU 2*3; stop on cycle 3 -> busy drops the next cycle, hi=0x1234, lo unchanged.
5. MTLO 0xAA then MTLO 0xBB; restore next cycle -> lo=0xAA. MULT issued while busy -> invalid=1, hi/lo unaffected.
6. With MDU_MADD_EN: hi=0, lo=10; MADD 3*4 -> after 5 cycles lo=22. Without MDU_MADD_EN: same op -> invalid=1, lo=10.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multi-cycle multiply/divide unit.
//   - 4-bit op codes (NOP=0 .. MSUBU=12; 13..15 unused)
//   - FSM state encoding (IDLE, BUSY)
//   - classifier helpers: is_start, is_div, is_mt, is_supported
// Optional feature macro: MDU_MADD_EN (MADD/MADDU/MSUB/MSUBU become start ops).
package mdu_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Ops that occupy the unit for several cycles and commit {hi,lo} at the end.
  function automatic logic is_start(input logic [3:0] op);
    logic r;
    r = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
`ifdef MDU_MADD_EN
    r = r || (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`endif
    return r;
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_mt(input logic [3:0] op);
    return (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

  function automatic logic is_supported(input logic [3:0] op);
    return (op == OP_NOP) || is_start(op) || is_mt(op) || (op == OP_MFHI) || (op == OP_MFLO);
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core: combinational signed/unsigned divider.
// Ports:
//   i_signed   - 1: two's-complement divide, 0: unsigned
//   i_dividend - dividend (rs)
//   i_divisor  - divisor  (rt)
//   o_quot     - quotient
//   o_rem      - remainder, carries the dividend's sign
// Divide by zero gives quot = all ones, rem = dividend.
// Signed MIN / -1 gives quot = MIN, rem = 0.
module mdu_div_core #(
  parameter int DATA_W = 32
) (
  input  logic              i_signed,
  input  logic [DATA_W-1:0] i_dividend,
  input  logic [DATA_W-1:0] i_divisor,
  output logic [DATA_W-1:0] o_quot,
  output logic [DATA_W-1:0] o_rem
);

  localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

  logic              w_a_neg;
  logic              w_b_neg;
  logic [DATA_W-1:0] w_a_mag;
  logic [DATA_W-1:0] w_b_mag;
  logic [DATA_W-1:0] w_b_safe;
  logic [DATA_W-1:0] w_q_mag;
  logic [DATA_W-1:0] w_r_mag;

  // Divide magnitudes, then restore signs.
  assign w_a_neg  = i_signed & i_dividend[DATA_W-1];
  assign w_b_neg  = i_signed & i_divisor[DATA_W-1];
  assign w_a_mag  = w_a_neg ? (~i_dividend + 1'b1) : i_dividend;
  assign w_b_mag  = w_b_neg ? (~i_divisor + 1'b1) : i_divisor;
  // Keep the raw divider away from a zero divisor; that case is overridden below.
  assign w_b_safe = (i_divisor == '0) ? {{(DATA_W-1){1'b0}}, 1'b1} : w_b_mag;
  assign w_q_mag  = w_a_mag / w_b_safe;
  assign w_r_mag  = w_a_mag % w_b_safe;

  always_comb begin
    o_quot = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 1'b1) : w_q_mag;
    o_rem  = w_a_neg ? (~w_r_mag + 1'b1) : w_r_mag;
    if (i_divisor == '0) begin
      o_quot = '1;
      o_rem  = i_dividend;
    end else if (i_signed && (i_dividend == MIN_VAL) && (i_divisor == '1)) begin
      o_quot = MIN_VAL;
      o_rem  = '0;
    end
  end

endmodule

// File: rtl/mdu_multicycle.sv
// mdu_multicycle: multi-cycle multiply/divide unit owning HI/LO.
// Ports:
//   clk, rst      - clock; asynchronous active-low reset
//   dh, dl        - operands (rs, rt)
//   op            - op code (mdu_pkg), sampled every rising edge
//   stop          - cancel in-flight op, HI/LO untouched
//   restore       - roll HI/LO back to the snapshot taken at the last start/MT
//   busy          - operation in flight
//   invalid       - op unsupported, or start/MT op presented while busy
//   hi, lo        - HI/LO registers
//   out           - hi for MFHI, lo for MFLO, else 0
//   dbg_state     - current FSM state (IDLE=0, BUSY=1)
// Result is computed at issue and held in pending regs; the FSM only counts
// down and commits, so latency from issue to visible hi/lo is exactly N edges.
// Edge priority: restore > stop > commit > new issue.
// Optional macro MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
module mdu_multicycle
  import mdu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] dh,
  input  logic [DATA_W-1:0] dl,
  input  logic [3:0]        op,
  input  logic              stop,
  input  logic              restore,
  output logic              busy,
  output logic              invalid,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] out,
  output logic              dbg_state
);

  localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t              r_state, w_state_nx;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nx;
  logic [DATA_W-1:0]   r_hi, w_hi_nx;
  logic [DATA_W-1:0]   r_lo, w_lo_nx;
  logic [2*DATA_W-1:0] r_snap, w_snap_nx;
  logic [2*DATA_W-1:0] r_pend, w_pend_nx;

  logic [2*DATA_W-1:0] w_prod_s;
  logic [2*DATA_W-1:0] w_prod_u;
  logic [2*DATA_W-1:0] w_result;
  logic [DATA_W-1:0]   w_quot;
  logic [DATA_W-1:0]   w_rem;

  // Sign-extended operands multiplied unsigned give the correct signed low 2W bits.
  assign w_prod_s = {{DATA_W{dh[DATA_W-1]}}, dh} * {{DATA_W{dl[DATA_W-1]}}, dl};
  assign w_prod_u = {{DATA_W{1'b0}}, dh} * {{DATA_W{1'b0}}, dl};

  mdu_div_core #(.DATA_W(DATA_W)) u_div (
    .i_signed   (op == OP_DIV),
    .i_dividend (dh),
    .i_divisor  (dl),
    .o_quot     (w_quot),
    .o_rem      (w_rem)
  );

  always_comb begin
    w_result = '0;
    case (op)
      OP_MULT:  w_result = w_prod_s;
      OP_MULTU: w_result = w_prod_u;
      OP_DIV,
      OP_DIVU:  w_result = {w_rem, w_quot};
`ifdef MDU_MADD_EN
      OP_MADD:  w_result = {r_hi, r_lo} + w_prod_s;
      OP_MADDU: w_result = {r_hi, r_lo} + w_prod_u;
      OP_MSUB:  w_result = {r_hi, r_lo} - w_prod_s;
      OP_MSUBU: w_result = {r_hi, r_lo} - w_prod_u;
`endif
      default:  w_result = '0;
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_hi_nx    = r_hi;
    w_lo_nx    = r_lo;
    w_snap_nx  = r_snap;
    w_pend_nx  = r_pend;
    if (restore) begin
      {w_hi_nx, w_lo_nx} = r_snap;
      w_state_nx         = ST_IDLE;
      w_cnt_nx           = '0;
    end else if (r_state == ST_BUSY) begin
      if (stop) begin
        w_state_nx = ST_IDLE;
        w_cnt_nx   = '0;
      end else if (r_cnt == CNT_W'(1)) begin
        {w_hi_nx, w_lo_nx} = r_pend;
        w_state_nx         = ST_IDLE;
        w_cnt_nx           = '0;
      end else begin
        w_cnt_nx = r_cnt - CNT_W'(1);
      end
    end else begin
      // A start presented alongside stop belongs to a flushed instruction.
      if (is_start(op) && !stop) begin
        w_snap_nx  = {r_hi, r_lo};
        w_pend_nx  = w_result;
        w_cnt_nx   = is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
        w_state_nx = ST_BUSY;
      end else if (op == OP_MTHI) begin
        w_snap_nx = {r_hi, r_lo};
        w_hi_nx   = dh;
      end else if (op == OP_MTLO) begin
        w_snap_nx = {r_hi, r_lo};
        w_lo_nx   = dh;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_snap  <= '0;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_hi    <= w_hi_nx;
      r_lo    <= w_lo_nx;
      r_snap  <= w_snap_nx;
      r_pend  <= w_pend_nx;
    end
  end

  assign busy      = (r_state == ST_BUSY);
  assign invalid   = !is_supported(op) || (busy && (is_start(op) || is_mt(op)));
  assign hi        = r_hi;
  assign lo        = r_lo;
  assign out       = (op == OP_MFHI) ? r_hi : ((op == OP_MFLO) ? r_lo : '0);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mdu_multicycle.sv
// tb_mdu_multicycle: directed self-checking bench for mdu_multicycle.
// Inputs change 1ns after a rising edge; outputs are sampled there too.
// Handshake: op is a one-cycle command; the bench holds it for exactly one
// edge and returns to NOP, and only issues a new start once busy is low.
module tb_mdu_multicycle;
  import mdu_pkg::*;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] dh, dl;
  logic [3:0]   op;
  logic         stop, restore;
  logic         busy, invalid;
  logic [W-1:0] hi, lo, out;
  logic         dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  // clock / reset
  always #5 clk = ~clk;

  mdu_multicycle #(.DATA_W(W), .MUL_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .dh(dh), .dl(dl), .op(op), .stop(stop), .restore(restore),
    .busy(busy), .invalid(invalid), .hi(hi), .lo(lo), .out(out), .dbg_state(dbg_state)
  );

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op = o; dh = a; dl = b;
    tick(1);
    op = OP_NOP;
  endtask

  task automatic test_reset();
    rst = 1'b0; op = OP_NOP; dh = '0; dl = '0; stop = 1'b0; restore = 1'b0;
    #3;
    n_cmp++; if ({busy, hi, lo} !== {1'b0, 64'h0}) begin n_err++; $display("FAIL reset_state: got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo); end
    n_cmp++; if ({invalid, out} !== {1'b0, 32'h0}) begin n_err++; $display("FAIL reset_outs: got invalid=%b out=%h want 0/0", invalid, out); end
    #4 rst = 1'b1;
    tick(1);
  endtask

  task automatic test_mult();
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    for (int i = 0; i < MC; i++) begin
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mult_busy[%0d]: got %b want 1", i, busy); end
      if (i == MC - 1) begin
        n_cmp++; if (lo !== 32'h0) begin n_err++; $display("FAIL mult_early_commit: got lo=%h want 0", lo); end
      end
      tick(1);
    end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mult_busy_end: got %b want 0", busy); end
    n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
    n_cmp++; if (lo !== 32'hFFFF_FFFA) begin n_err++; $display("FAIL mult_lo: got %h want fffffffa", lo); end
  endtask

  task automatic test_div();
    issue(OP_DIVU, 32'd100, 32'd7);
    tick(DC - 1);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL divu_busy_last: got %b want 1", busy); end
    tick(1);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL divu_busy_end: got %b want 0", busy); end
    n_cmp++; if ({hi, lo} !== {32'd2, 32'd14}) begin n_err++; $display("FAIL divu_res: got hi=%h lo=%h want 2/e", hi, lo); end
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    tick(DC);
    n_cmp++; if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin n_err++; $display("FAIL div_neg: got hi=%h lo=%h want ffffffff/fffffffd", hi, lo); end
  endtask

  task automatic test_div_edges();
    issue(OP_DIV, 32'd5, 32'd0);
    tick(DC);
    n_cmp++; if ({hi, lo} !== {32'd5, 32'hFFFF_FFFF}) begin n_err++; $display("FAIL div_zero: got hi=%h lo=%h want 5/ffffffff", hi, lo); end
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    tick(DC);
    n_cmp++; if ({hi, lo} !== {32'h0, 32'h8000_0000}) begin n_err++; $display("FAIL div_ovf: got hi=%h lo=%h want 0/80000000", hi, lo); end
  endtask

  task automatic test_stop();
    issue(OP_MTHI, 32'h1234, 32'd0);
    issue(OP_MTLO, 32'h55, 32'd0);
    issue(OP_MULTU, 32'd2, 32'd3);
    tick(2);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL stop_busy: got %b want 0", busy); end
    tick(MC);
    n_cmp++; if ({hi, lo} !== {32'h1234, 32'h55}) begin n_err++; $display("FAIL stop_hilo: got hi=%h lo=%h want 1234/55", hi, lo); end
    // stop landing on the commit edge wins
    issue(OP_MULTU, 32'd2, 32'd3);
    tick(MC - 1);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    n_cmp++; if ({busy, hi, lo} !== {1'b0, 32'h1234, 32'h55}) begin n_err++; $display("FAIL stop_commit_edge: got busy=%b hi=%h lo=%h want 0/1234/55", busy, hi, lo); end
    // start alongside stop in IDLE is discarded
    stop = 1'b1;
    issue(OP_MULT, 32'd9, 32'd9);
    stop = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL stop_discard_start: got busy=%b want 0", busy); end
  endtask

  task automatic test_restore_invalid();
    issue(OP_MTLO, 32'hAA, 32'd0);
    issue(OP_MTLO, 32'hBB, 32'd0);
    n_cmp++; if (lo !== 32'hBB) begin n_err++; $display("FAIL mtlo_bb: got %h want bb", lo); end
    restore = 1'b1;
    tick(1);
    restore = 1'b0;
    n_cmp++; if ({hi, lo} !== {32'h1234, 32'hAA}) begin n_err++; $display("FAIL restore_mt: got hi=%h lo=%h want 1234/aa", hi, lo); end
    issue(OP_MULT, 32'd7, 32'd6);
    op = OP_MULT; dh = 32'd1; dl = 32'd1;
    #1;
    n_cmp++; if (invalid !== 1'b1) begin n_err++; $display("FAIL busy_start_invalid: got %b want 1", invalid); end
    tick(1);
    op = OP_MTHI; dh = 32'hDEAD;
    #1;
    n_cmp++; if (invalid !== 1'b1) begin n_err++; $display("FAIL busy_mt_invalid: got %b want 1", invalid); end
    tick(1);
    op = OP_MFHI;
    #1;
    n_cmp++; if ({invalid, out} !== {1'b0, 32'h1234}) begin n_err++; $display("FAIL busy_mfhi: got invalid=%b out=%h want 0/1234", invalid, out); end
    op = OP_NOP;
    tick(MC - 2);
    n_cmp++; if ({busy, hi, lo} !== {1'b0, 32'h0, 32'd42}) begin n_err++; $display("FAIL mult_after_ignored: got busy=%b hi=%h lo=%h want 0/0/2a", busy, hi, lo); end
    issue(OP_MULTU, 32'h1_0000, 32'h1_0000);
    tick(MC);
    n_cmp++; if ({hi, lo} !== {32'h1, 32'h0}) begin n_err++; $display("FAIL multu_big: got hi=%h lo=%h want 1/0", hi, lo); end
    restore = 1'b1;
    tick(1);
    restore = 1'b0;
    n_cmp++; if ({hi, lo} !== {32'h0, 32'd42}) begin n_err++; $display("FAIL restore_md: got hi=%h lo=%h want 0/2a", hi, lo); end
    op = 4'd15;
    #1;
    n_cmp++; if (invalid !== 1'b1) begin n_err++; $display("FAIL op15_invalid: got %b want 1", invalid); end
    tick(1);
    op = OP_NOP;
    n_cmp++; if ({busy, hi, lo} !== {1'b0, 32'h0, 32'd42}) begin n_err++; $display("FAIL op15_nop: got busy=%b hi=%h lo=%h", busy, hi, lo); end
  endtask

  task automatic test_mf();
    issue(OP_MTHI, 32'hCAFE, 32'd0);
    issue(OP_MTLO, 32'hBEEF, 32'd0);
    op = OP_MFHI; #1;
    n_cmp++; if (out !== 32'hCAFE) begin n_err++; $display("FAIL mfhi: got %h want cafe", out); end
    op = OP_MFLO; #1;
    n_cmp++; if (out !== 32'hBEEF) begin n_err++; $display("FAIL mflo: got %h want beef", out); end
    op = OP_NOP; #1;
    n_cmp++; if (out !== 32'h0) begin n_err++; $display("FAIL out_nop: got %h want 0", out); end
  endtask

  task automatic test_madd();
    issue(OP_MTHI, 32'd0, 32'd0);
    issue(OP_MTLO, 32'd10, 32'd0);
    op = OP_MADD; dh = 32'd3; dl = 32'd4;
    #1;
`ifdef MDU_MADD_EN
    n_cmp++; if (invalid !== 1'b0) begin n_err++; $display("FAIL madd_valid: got %b want 0", invalid); end
    tick(1);
    op = OP_NOP;
    tick(MC);
    n_cmp++; if ({busy, hi, lo} !== {1'b0, 32'h0, 32'd22}) begin n_err++; $display("FAIL madd_res: got busy=%b hi=%h lo=%h want 0/0/16", busy, hi, lo); end
    issue(OP_MSUB, 32'd5, 32'd5);
    tick(MC);
    n_cmp++; if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin n_err++; $display("FAIL msub_res: got hi=%h lo=%h want ffffffff/fffffffd", hi, lo); end
`else
    n_cmp++; if (invalid !== 1'b1) begin n_err++; $display("FAIL madd_invalid: got %b want 1", invalid); end
    tick(1);
    op = OP_NOP;
    tick(MC);
    n_cmp++; if ({busy, hi, lo} !== {1'b0, 32'h0, 32'd10}) begin n_err++; $display("FAIL madd_nop: got busy=%b hi=%h lo=%h want 0/0/a", busy, hi, lo); end
`endif
  endtask

  task automatic test_reset_mid_op();
    issue(OP_DIVU, 32'd50, 32'd3);
    tick(3);
    #2 rst = 1'b0;
    #1;
    n_cmp++; if ({busy, hi, lo} !== {1'b0, 64'h0}) begin n_err++; $display("FAIL reset_mid_op: got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo); end
    #2 rst = 1'b1;
    tick(DC + 1);
    n_cmp++; if ({busy, hi, lo} !== {1'b0, 64'h0}) begin n_err++; $display("FAIL reset_no_commit: got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_edges();
    test_stop();
    test_restore_invalid();
    test_mf();
    test_madd();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
